mem_wb_stage: RTL

- MEM/WB pipeline stage of the 5-stage MIPS32 core: registers the MEM-stage result, extracts and sign/zero-extends load data from the raw data-memory word, and drives the register-file write port (we/waddr/wdata) one cycle later.
- Sits directly upstream of the register file; its outputs are also the WB forwarding source for the ID stage.
- Stall and flush come from the pipeline control unit.

---
 rtl/mem_wb_stage_pkg.sv | 30 +++
 rtl/mem_wb_stage_load_align.sv | 56 +++++
 rtl/mem_wb_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage.
// Contents: datapath widths, load-op encodings, common constants and a
// helper that tells load ops apart from non-load/reserved codes.
package mem_wb_stage_pkg;

   localparam int unsigned DATA_W = 32;   // RegBus width
   localparam int unsigned ADDR_W = 5;    // RegAddrBus width
   localparam int unsigned LDOP_W = 3;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [LDOP_W-1:0] {
      LDOP_NONE = 3'd0,
      LDOP_LB   = 3'd1,
      LDOP_LBU  = 3'd2,
      LDOP_LH   = 3'd3,
      LDOP_LHU  = 3'd4,
      LDOP_LW   = 3'd5
   } ldop_e;

   localparam logic [DATA_W-1:0] ZEROWORD  = '0;
   localparam logic              WRITEABLE = 1'b1;

   // Codes 6 and 7 are reserved and behave exactly like LDOP_NONE.
   function automatic logic is_load(input logic [LDOP_W-1:0] op);
      return (op >= LDOP_LB) && (op <= LDOP_LW);
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load data extraction and alignment check (combinational).
// Ports:
//   ldop        in  load type (ldop_e encoding, 6-7 reserved)
//   addr_lo     in  effective address bits [1:0]
//   rdata       in  raw aligned word from data memory
//   data_c      out extracted, sign/zero-extended load data (0 if not a load)
//   misalign_c  out LH/LHU with addr_lo[0]=1 or LW with addr_lo!=0
module mem_wb_stage_load_align
   import mem_wb_stage_pkg::*;
(
   input  logic [LDOP_W-1:0] ldop,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data_c,
   output logic              misalign_c
);

   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;

   // Byte lane 0 is the most significant byte.
   always_comb begin
      byte_v = '0;
      case (addr_lo)
         2'd0:    byte_v = rdata[31:24];
         2'd1:    byte_v = rdata[23:16];
         2'd2:    byte_v = rdata[15:8];
         default: byte_v = rdata[7:0];
      endcase
      half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   // Extension and alignment per load type.
   always_comb begin
      data_c     = ZEROWORD;
      misalign_c = 1'b0;
      case (ldop)
         LDOP_LB:  data_c = {{(DATA_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
         LDOP_LBU: data_c = {{(DATA_W-BYTE_W){1'b0}}, byte_v};
         LDOP_LH: begin
            misalign_c = addr_lo[0];
            data_c     = {{(DATA_W-HALF_W){half_v[HALF_W-1]}}, half_v};
         end
         LDOP_LHU: begin
            misalign_c = addr_lo[0];
            data_c     = {{(DATA_W-HALF_W){1'b0}}, half_v};
         end
         LDOP_LW: begin
            misalign_c = (addr_lo != 2'd0);
            data_c     = rdata;
         end
         default: data_c = ZEROWORD;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers the MEM result, extracts load data and
// drives the register-file write port one cycle later.
// Optional feature macro: WB_RETIRE_CNT_EN (adds wb_retire_cnt).
// Ports:
//   clk, rst         clock, async active-high reset
//   stall, flush     pipeline control (flush has priority over stall)
//   mem_wreg/mem_wd  MEM write enable / destination register
//   mem_wdata        non-load result
//   mem_ldop         load type, mem_addr_lo address bits [1:0]
//   mem_rdata        raw data-memory word
//   wb_we/waddr/wdata  registered register-file write port
//   wb_misalign      registered: misaligned load suppressed
//   wb_retire_cnt    (optional) count of captured register writes
module mem_wb_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [2:0]        mem_ldop,
   input  logic [1:0]        mem_addr_lo,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_waddr,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_misalign
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       wb_retire_cnt
`endif
);

   import mem_wb_stage_pkg::LDOP_W;
   import mem_wb_stage_pkg::WRITEABLE;
   import mem_wb_stage_pkg::is_load;

   logic [DATA_W-1:0] ld_data_c;
   logic              ld_misalign_c;
   logic              nxt_we_c;
   logic [DATA_W-1:0] nxt_wdata_c;

   mem_wb_stage_load_align u_load_align (
      .ldop       (LDOP_W'(mem_ldop)),
      .addr_lo    (mem_addr_lo),
      .rdata      (mem_rdata),
      .data_c     (ld_data_c),
      .misalign_c (ld_misalign_c)
   );

   // Next write-port values; $0 writes and misaligned loads never write.
   always_comb begin
      nxt_we_c    = 1'b0;
      nxt_wdata_c = mem_wdata;
      if (ld_misalign_c) begin
         nxt_wdata_c = '0;
      end else if (is_load(mem_ldop)) begin
         nxt_wdata_c = ld_data_c;
      end
      if (mem_wreg == WRITEABLE && !ld_misalign_c && mem_wd != '0) begin
         nxt_we_c = 1'b1;
      end
   end

   // Stage register: flush > stall > capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_we       <= 1'b0;
         wb_waddr    <= '0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (flush) begin
         wb_we       <= 1'b0;
         wb_waddr    <= '0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (!stall) begin
         wb_we       <= nxt_we_c;
         wb_waddr    <= mem_wd;
         wb_wdata    <= nxt_wdata_c;
         wb_misalign <= ld_misalign_c;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Counts captured register writes; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_retire_cnt <= '0;
      end else if (!flush && !stall && nxt_we_c) begin
         wb_retire_cnt <= wb_retire_cnt + 32'd1;
      end
   end
`endif

endmodule
